// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 asynchronous serial receiver with a one-deep holding register.
// The rx pin is synchronised by two flops, start bits are validated at
// mid-bit, and 8 data bits are sampled LSB-first at mid-bit. The stop bit is
// checked at mid-bit, and the byte is then offered to the holding register.
//
// Ports
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   clock_divider  clock cycles per bit period (floored at MIN_DIVIDER)
//   rx             serial input pin, asynchronous, idle high
//   read_en        one-cycle consume strobe (clears data_ready/overrun/frame_error)
//   data_out       last accepted byte
//   data_ready     holding register contains an unread byte
//   frame_error    sticky: a frame ended with stop bit = 0
//   overrun        sticky: a valid byte was dropped (holding register full)
//   busy           receiver is not idle
//
// State table
//   S_IDLE  | waiting for a falling edge on rx_s
//   S_START | timing half a bit to re-check the start bit
//   S_DATA  | sampling 8 data bits at mid-bit
//   S_STOP  | waiting for the mid-stop-bit sample
//   S_BREAK | stop bit was low; wait for the line to return high
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter logic [15:0] MIN_DIVIDER = 16'd2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] clock_divider,
    input  logic        rx,
    input  logic        read_en,
    output logic [7:0]  data_out,
    output logic        data_ready,
    output logic        frame_error,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      state, state_next;
    logic        rx_meta, rx_s;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  bit_idx, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic [15:0] d_eff;
    logic        sample;
    logic        accept;
    logic        frame_evt;

    // Divider floor; sampled every time the counter is reloaded.
    assign d_eff  = (clock_divider < MIN_DIVIDER) ? MIN_DIVIDER : clock_divider;
    assign sample = (cnt == 16'd0);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        accept     = 1'b0;
        frame_evt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    cnt_next   = (d_eff >> 1) - 16'd1;
                end
            end
            S_START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DATA;
                        bit_next   = 3'd0;
                        cnt_next   = d_eff - 16'd1;
                    end
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    cnt_next   = d_eff - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (sample) begin
                    if (rx_s) begin
                        accept     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_evt  = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            S_BREAK: begin
                // Held-low line: one frame_error, no repeated frames.
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Holding register and sticky flags. A set event in the same cycle as
    // read_en wins for that flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= 8'h00;
            data_ready  <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (accept && (!data_ready || read_en)) begin
                data_out   <= shift_reg;
                data_ready <= 1'b1;
            end else if (read_en) begin
                data_ready <= 1'b0;
            end

            if (accept && data_ready && !read_en) begin
                overrun <= 1'b1;
            end else if (read_en) begin
                overrun <= 1'b0;
            end

            if (frame_evt) begin
                frame_error <= 1'b1;
            end else if (read_en) begin
                frame_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Directed and randomised frames against a frame-level model of the
// receiver's holding register and sticky flags.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

    logic        clock;
    logic        reset_n;
    logic [15:0] clock_divider;
    logic        rx;
    logic        read_en;
    logic [7:0]  data_out;
    logic        data_ready;
    logic        frame_error;
    logic        overrun;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Frame-level model
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_ovr;
    logic       m_ferr;

    uart_rx_core dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .clock_divider (clock_divider),
        .rx            (rx),
        .read_en       (read_en),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .frame_error   (frame_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"},    {24'd0, data_out}, {24'd0, m_data});
        check({tag, ".data_ready"},  {31'd0, data_ready}, {31'd0, m_ready});
        check({tag, ".overrun"},     {31'd0, overrun}, {31'd0, m_ovr});
        check({tag, ".frame_error"}, {31'd0, frame_error}, {31'd0, m_ferr});
    endtask

    function automatic int eff_div(input logic [15:0] cd);
        return (cd < 16'd2) ? 2 : int'(cd);
    endfunction

    // Good stop bit: byte lands if the register is free or being read.
    function automatic void model_accept(input logic [7:0] b, input logic rd);
        if (!m_ready || rd) begin
            m_data  = b;
            m_ready = 1'b1;
            m_ovr   = rd ? 1'b0 : m_ovr;
            m_ferr  = rd ? 1'b0 : m_ferr;
        end else begin
            m_ovr = 1'b1;
        end
    endfunction

    function automatic void model_read();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endfunction

    function automatic void model_reset();
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d);
        rx = 1'b0;
        repeat (d) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (d) @(negedge clock);
        end
        rx = stop_bit;
        repeat (d) @(negedge clock);
    endtask

    task automatic do_read();
        read_en = 1'b1;
        @(negedge clock);
        read_en = 1'b0;
        model_read();
    endtask

    int         rise;
    int         d;
    logic [7:0] rb;
    logic       rstop;
    logic       rrd;

    initial begin
        reset_n       = 1'b0;
        rx            = 1'b1;
        read_en       = 1'b0;
        clock_divider = 16'd16;
        model_reset();
        idle(3);
        check_all("reset");
        check("reset.busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        idle(5);

        // Basic byte with latency measurement
        rise = -1;
        fork
            send_frame(8'h55, 1'b1, 16);
            begin
                for (int k = 1; k <= 200; k++) begin
                    @(negedge clock);
                    if (data_ready && rise < 0) rise = k;
                end
            end
        join
        model_accept(8'h55, 1'b0);
        check_all("basic");
        check($sformatf("basic.latency(%0d)", rise), {31'd0, (rise >= 154 && rise <= 156)}, 32'd1);
        do_read();
        @(negedge clock);
        check_all("basic_read");

        // Glitch rejection
        rx = 1'b0;
        idle(3);
        check("glitch.busy_hi", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        idle(12);
        check("glitch.busy_lo", {31'd0, busy}, 32'd0);
        check_all("glitch");

        // Framing error followed by a held-low line
        send_frame(8'hA3, 1'b0, 16);
        idle(40);
        m_ferr = 1'b1;
        check_all("ferr");
        check("ferr.busy_held", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        idle(6);
        check("ferr.busy_released", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 1'b1, 16);
        idle(3);
        model_accept(8'h3C, 1'b0);
        check_all("ferr_recover");
        do_read();

        // Overrun: back-to-back frames without a read
        send_frame(8'h12, 1'b1, 16);
        send_frame(8'h34, 1'b1, 16);
        idle(3);
        model_accept(8'h12, 1'b0);
        model_accept(8'h34, 1'b0);
        check_all("overrun");
        do_read();
        @(negedge clock);
        check_all("overrun_read");

        // read_en coincident with the accept edge of a new byte
        send_frame(8'h55, 1'b1, 16);
        idle(3);
        model_accept(8'h55, 1'b0);
        fork
            send_frame(8'h77, 1'b1, 16);
            begin
                repeat (2 + 8 + 9 * 16) @(negedge clock);
                read_en = 1'b1;
                @(negedge clock);
                read_en = 1'b0;
            end
        join
        idle(3);
        model_accept(8'h77, 1'b1);
        check_all("read_coincident");

        // Divider floor: 0 behaves as 2
        clock_divider = 16'd0;
        idle(2);
        send_frame(8'hF0, 1'b1, 2);
        idle(3);
        model_accept(8'hF0, 1'b0);
        check_all("floor");

        // Reset mid-DATA
        clock_divider = 16'd16;
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(16);
        rx = 1'b0;
        idle(10);
        check("midreset.busy_pre", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        rx      = 1'b1;
        @(negedge clock);
        model_reset();
        check_all("midreset");
        check("midreset.busy", {31'd0, busy}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(20);
        check("midreset.idle", {31'd0, busy}, 32'd0);
        send_frame(8'h81, 1'b1, 16);
        idle(3);
        model_accept(8'h81, 1'b0);
        check_all("after_reset");
        do_read();

        // Randomised frames, dividers, stop bits and reads
        for (int i = 0; i < 10; i++) begin
            clock_divider = 16'($urandom_range(0, 20));
            d     = eff_div(clock_divider);
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rrd   = $urandom_range(0, 1) == 1;
            idle(2);
            send_frame(rb, rstop, d);
            if (rstop) begin
                model_accept(rb, 1'b0);
            end else begin
                m_ferr = 1'b1;
                rx = 1'b1;
            end
            idle(4);
            check_all($sformatf("rand%0d", i));
            if (rrd) begin
                do_read();
                @(negedge clock);
                check_all($sformatf("rand%0d_read", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
